// File: rtl/fp_execute_stage2.sv
// Floating-point pipeline stage 2: aligns the smaller-exponent significand,
// extracts guard/round/sticky, and forms the 64-bit unsigned significand product.
module fp_execute_stage2 #(
    parameter  int unsigned NUM_VECTOR_LANES = 16,
    localparam int unsigned INSTR_W          = 32,
    localparam int unsigned THREAD_W         = 2,
    localparam int unsigned SUBCYCLE_W       = 4,
    localparam int unsigned SCALAR_W         = 32,
    localparam int unsigned SHIFT_W          = 6,
    localparam int unsigned EXP_W            = 8,
    localparam int unsigned PROD_W           = 2 * SCALAR_W
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        fx1_instruction_valid,
    input  logic [INSTR_W-1:0]          fx1_instruction,
    input  logic [NUM_VECTOR_LANES-1:0] fx1_mask_value,
    input  logic [THREAD_W-1:0]         fx1_thread_idx,
    input  logic [SUBCYCLE_W-1:0]       fx1_subcycle,
    input  logic                        fx1_result_is_inf    [NUM_VECTOR_LANES],
    input  logic                        fx1_result_is_nan    [NUM_VECTOR_LANES],
    input  logic [SHIFT_W-1:0]          fx1_ftoi_lshift      [NUM_VECTOR_LANES],
    input  logic [SCALAR_W-1:0]         fx1_significand_le   [NUM_VECTOR_LANES],
    input  logic [SCALAR_W-1:0]         fx1_significand_se   [NUM_VECTOR_LANES],
    input  logic [SHIFT_W-1:0]          fx1_se_align_shift   [NUM_VECTOR_LANES],
    input  logic [EXP_W-1:0]            fx1_add_exponent     [NUM_VECTOR_LANES],
    input  logic                        fx1_logical_subtract [NUM_VECTOR_LANES],
    input  logic                        fx1_add_result_sign  [NUM_VECTOR_LANES],
    input  logic [SCALAR_W-1:0]         fx1_multiplicand     [NUM_VECTOR_LANES],
    input  logic [SCALAR_W-1:0]         fx1_multiplier       [NUM_VECTOR_LANES],
    input  logic [EXP_W-1:0]            fx1_mul_exponent     [NUM_VECTOR_LANES],
    input  logic                        fx1_mul_sign         [NUM_VECTOR_LANES],

    output logic                        fx2_instruction_valid,
    output logic [INSTR_W-1:0]          fx2_instruction,
    output logic [NUM_VECTOR_LANES-1:0] fx2_mask_value,
    output logic [THREAD_W-1:0]         fx2_thread_idx,
    output logic [SUBCYCLE_W-1:0]       fx2_subcycle,
    output logic                        fx2_result_is_inf       [NUM_VECTOR_LANES],
    output logic                        fx2_result_is_nan       [NUM_VECTOR_LANES],
    output logic [SHIFT_W-1:0]          fx2_ftoi_lshift         [NUM_VECTOR_LANES],
    output logic [SCALAR_W-1:0]         fx2_significand_le      [NUM_VECTOR_LANES],
    output logic [SCALAR_W-1:0]         fx2_significand_se      [NUM_VECTOR_LANES],
    output logic                        fx2_guard               [NUM_VECTOR_LANES],
    output logic                        fx2_round               [NUM_VECTOR_LANES],
    output logic                        fx2_sticky              [NUM_VECTOR_LANES],
    output logic [EXP_W-1:0]            fx2_add_exponent        [NUM_VECTOR_LANES],
    output logic                        fx2_logical_subtract    [NUM_VECTOR_LANES],
    output logic                        fx2_add_result_sign     [NUM_VECTOR_LANES],
    output logic [PROD_W-1:0]           fx2_significand_product [NUM_VECTOR_LANES],
    output logic [EXP_W-1:0]            fx2_mul_exponent        [NUM_VECTOR_LANES],
    output logic                        fx2_mul_sign            [NUM_VECTOR_LANES]
);

    localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(SCALAR_W);

    logic [SHIFT_W-1:0] w_shift   [NUM_VECTOR_LANES];
    logic [PROD_W-1:0]  w_ext     [NUM_VECTOR_LANES];
    logic [PROD_W-1:0]  w_product [NUM_VECTOR_LANES];

    // Shift {x, 32'b0} right: upper half is the aligned significand, the next
    // two bits are guard/round and everything below ORs into sticky.
    always_comb begin
        for (int i = 0; i < NUM_VECTOR_LANES; i++) begin
            w_shift[i]   = (fx1_se_align_shift[i] > MAX_SHIFT) ? MAX_SHIFT
                                                               : fx1_se_align_shift[i];
            w_ext[i]     = {fx1_significand_se[i], SCALAR_W'(0)} >> w_shift[i];
            w_product[i] = PROD_W'(fx1_multiplicand[i]) * PROD_W'(fx1_multiplier[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fx2_instruction_valid <= 1'b0;
            fx2_instruction       <= '0;
            fx2_mask_value        <= '0;
            fx2_thread_idx        <= '0;
            fx2_subcycle          <= '0;
            for (int i = 0; i < NUM_VECTOR_LANES; i++) begin
                fx2_result_is_inf[i]       <= 1'b0;
                fx2_result_is_nan[i]       <= 1'b0;
                fx2_ftoi_lshift[i]         <= '0;
                fx2_significand_le[i]      <= '0;
                fx2_significand_se[i]      <= '0;
                fx2_guard[i]               <= 1'b0;
                fx2_round[i]               <= 1'b0;
                fx2_sticky[i]              <= 1'b0;
                fx2_add_exponent[i]        <= '0;
                fx2_logical_subtract[i]    <= 1'b0;
                fx2_add_result_sign[i]     <= 1'b0;
                fx2_significand_product[i] <= '0;
                fx2_mul_exponent[i]        <= '0;
                fx2_mul_sign[i]            <= 1'b0;
            end
        end else begin
            fx2_instruction_valid <= fx1_instruction_valid;
            fx2_instruction       <= fx1_instruction;
            fx2_mask_value        <= fx1_mask_value;
            fx2_thread_idx        <= fx1_thread_idx;
            fx2_subcycle          <= fx1_subcycle;
            for (int i = 0; i < NUM_VECTOR_LANES; i++) begin
                fx2_result_is_inf[i]       <= fx1_result_is_inf[i];
                fx2_result_is_nan[i]       <= fx1_result_is_nan[i];
                fx2_ftoi_lshift[i]         <= fx1_ftoi_lshift[i];
                fx2_significand_le[i]      <= fx1_significand_le[i];
                fx2_significand_se[i]      <= w_ext[i][PROD_W-1:SCALAR_W];
                fx2_guard[i]               <= w_ext[i][SCALAR_W-1];
                fx2_round[i]               <= w_ext[i][SCALAR_W-2];
                fx2_sticky[i]              <= |w_ext[i][SCALAR_W-3:0];
                fx2_add_exponent[i]        <= fx1_add_exponent[i];
                fx2_logical_subtract[i]    <= fx1_logical_subtract[i];
                fx2_add_result_sign[i]     <= fx1_add_result_sign[i];
                fx2_significand_product[i] <= w_product[i];
                fx2_mul_exponent[i]        <= fx1_mul_exponent[i];
                fx2_mul_sign[i]            <= fx1_mul_sign[i];
            end
        end
    end

endmodule

// File: tb/tb_fp_execute_stage2.sv
// Directed-vector bench for fp_execute_stage2: alignment/GRS table, products,
// lane independence, passthrough ordering and mid-stream reset.
module tb_fp_execute_stage2;

    localparam int unsigned NL = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_instr;
    logic [15:0] i_mask;
    logic [1:0]  i_thread;
    logic [3:0]  i_subcycle;
    logic        i_inf [NL];
    logic        i_nan [NL];
    logic [5:0]  i_lshift [NL];
    logic [31:0] i_le [NL];
    logic [31:0] i_se [NL];
    logic [5:0]  i_shift [NL];
    logic [7:0]  i_add_exp [NL];
    logic        i_lsub [NL];
    logic        i_add_sign [NL];
    logic [31:0] i_mcand [NL];
    logic [31:0] i_mplier [NL];
    logic [7:0]  i_mul_exp [NL];
    logic        i_mul_sign [NL];

    logic        o_valid;
    logic [31:0] o_instr;
    logic [15:0] o_mask;
    logic [1:0]  o_thread;
    logic [3:0]  o_subcycle;
    logic        o_inf [NL];
    logic        o_nan [NL];
    logic [5:0]  o_lshift [NL];
    logic [31:0] o_le [NL];
    logic [31:0] o_se [NL];
    logic        o_guard [NL];
    logic        o_round [NL];
    logic        o_sticky [NL];
    logic [7:0]  o_add_exp [NL];
    logic        o_lsub [NL];
    logic        o_add_sign [NL];
    logic [63:0] o_prod [NL];
    logic [7:0]  o_mul_exp [NL];
    logic        o_mul_sign [NL];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    fp_execute_stage2 #(.NUM_VECTOR_LANES(NL)) dut (
        .clk(clk), .reset(reset),
        .fx1_instruction_valid(i_valid), .fx1_instruction(i_instr),
        .fx1_mask_value(i_mask), .fx1_thread_idx(i_thread), .fx1_subcycle(i_subcycle),
        .fx1_result_is_inf(i_inf), .fx1_result_is_nan(i_nan),
        .fx1_ftoi_lshift(i_lshift), .fx1_significand_le(i_le),
        .fx1_significand_se(i_se), .fx1_se_align_shift(i_shift),
        .fx1_add_exponent(i_add_exp), .fx1_logical_subtract(i_lsub),
        .fx1_add_result_sign(i_add_sign), .fx1_multiplicand(i_mcand),
        .fx1_multiplier(i_mplier), .fx1_mul_exponent(i_mul_exp), .fx1_mul_sign(i_mul_sign),
        .fx2_instruction_valid(o_valid), .fx2_instruction(o_instr),
        .fx2_mask_value(o_mask), .fx2_thread_idx(o_thread), .fx2_subcycle(o_subcycle),
        .fx2_result_is_inf(o_inf), .fx2_result_is_nan(o_nan),
        .fx2_ftoi_lshift(o_lshift), .fx2_significand_le(o_le),
        .fx2_significand_se(o_se), .fx2_guard(o_guard), .fx2_round(o_round),
        .fx2_sticky(o_sticky), .fx2_add_exponent(o_add_exp),
        .fx2_logical_subtract(o_lsub), .fx2_add_result_sign(o_add_sign),
        .fx2_significand_product(o_prod), .fx2_mul_exponent(o_mul_exp),
        .fx2_mul_sign(o_mul_sign)
    );

    typedef struct {
        logic [31:0] x;
        logic [5:0]  s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_se;
        logic        e_g;
        logic        e_r;
        logic        e_st;
        logic [63:0] e_prod;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_valid = 1'b0; i_instr = '0; i_mask = '0; i_thread = '0; i_subcycle = '0;
        for (int j = 0; j < NL; j++) begin
            i_inf[j] = 1'b0; i_nan[j] = 1'b0; i_lshift[j] = '0; i_le[j] = '0;
            i_se[j] = '0; i_shift[j] = '0; i_add_exp[j] = '0; i_lsub[j] = 1'b0;
            i_add_sign[j] = 1'b0; i_mcand[j] = '0; i_mplier[j] = '0;
            i_mul_exp[j] = '0; i_mul_sign[j] = 1'b0;
        end
    endtask

    // Loads every input with nonzero junk so a reset edge has something to override.
    task automatic fill_busy_inputs();
        i_valid = 1'b1; i_instr = 32'hDEAD_BEEF; i_mask = 16'hFFFF;
        i_thread = 2'd3; i_subcycle = 4'hF;
        for (int j = 0; j < NL; j++) begin
            i_inf[j] = 1'b1; i_nan[j] = 1'b1; i_lshift[j] = 6'd17; i_le[j] = 32'hFFFF_FFFF;
            i_se[j] = 32'hFFFF_FFFF; i_shift[j] = 6'd5; i_add_exp[j] = 8'hFF;
            i_lsub[j] = 1'b1; i_add_sign[j] = 1'b1; i_mcand[j] = 32'hFFFF_FFFF;
            i_mplier[j] = 32'hFFFF_FFFF; i_mul_exp[j] = 8'hFF; i_mul_sign[j] = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        int nz;
        chk({tag, " valid"},  64'(o_valid),    64'd0);
        chk({tag, " instr"},  64'(o_instr),    64'd0);
        chk({tag, " mask"},   64'(o_mask),     64'd0);
        chk({tag, " thread"}, 64'(o_thread),   64'd0);
        chk({tag, " subcyc"}, 64'(o_subcycle), 64'd0);
        nz = 0;
        for (int j = 0; j < NL; j++) begin
            if (o_inf[j] || o_nan[j] || o_lshift[j] != 0 || o_le[j] != 0 || o_se[j] != 0 ||
                o_guard[j] || o_round[j] || o_sticky[j] || o_add_exp[j] != 0 || o_lsub[j] ||
                o_add_sign[j] || o_prod[j] != 0 || o_mul_exp[j] != 0 || o_mul_sign[j])
                nz++;
        end
        chk({tag, " nonzero lanes"}, 64'(nz), 64'd0);
    endtask

    // Passthrough stimulus as a function of slot index k.
    function automatic logic [31:0] pt_instr(int k);  return 32'hC0DE_0000 | 32'(k);   endfunction
    function automatic logic [15:0] pt_mask(int k);   return 16'(16'h000F << (4 * k)); endfunction
    function automatic logic [31:0] pt_le(int k, int j); return 32'h1000_0000 + 32'(16 * k + j); endfunction

    task automatic drive_pt(input int k);
        i_valid = 1'b1; i_instr = pt_instr(k); i_mask = pt_mask(k);
        i_thread = 2'(k); i_subcycle = 4'(k + 3);
        for (int j = 0; j < NL; j++) begin
            i_inf[j] = (j == k); i_nan[j] = (j == k + 4);
            i_lshift[j] = 6'(j + k); i_le[j] = pt_le(k, j);
            i_add_exp[j] = 8'(16 * k + j); i_lsub[j] = ((j + k) % 2) == 1;
            i_add_sign[j] = (k % 2) == 1; i_mul_exp[j] = 8'(200 + k);
            i_mul_sign[j] = (k == 2);
        end
    endtask

    task automatic chk_pt(input int k);
        int bad;
        chk($sformatf("pt%0d valid", k),  64'(o_valid),    64'd1);
        chk($sformatf("pt%0d instr", k),  64'(o_instr),    64'(pt_instr(k)));
        chk($sformatf("pt%0d mask", k),   64'(o_mask),     64'(pt_mask(k)));
        chk($sformatf("pt%0d thread", k), 64'(o_thread),   64'(k));
        chk($sformatf("pt%0d subcyc", k), 64'(o_subcycle), 64'(k + 3));
        bad = 0;
        for (int j = 0; j < NL; j++) begin
            if (o_inf[j] !== (j == k) || o_nan[j] !== (j == k + 4) ||
                o_lshift[j] !== 6'(j + k) || o_le[j] !== pt_le(k, j) ||
                o_add_exp[j] !== 8'(16 * k + j) || o_lsub[j] !== (((j + k) % 2) == 1) ||
                o_add_sign[j] !== ((k % 2) == 1) || o_mul_exp[j] !== 8'(200 + k) ||
                o_mul_sign[j] !== (k == 2))
                bad++;
        end
        chk($sformatf("pt%0d lane fields", k), 64'(bad), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{32'h00FF_FFFF, 6'd0,  32'd3,          32'd5,          32'h00FF_FFFF, 1'b0, 1'b0, 1'b0, 64'd15};
        tbl[1]  = '{32'h00FF_FFFF, 6'd1,  32'd0,          32'hFFFF_FFFF,  32'h007F_FFFF, 1'b1, 1'b0, 1'b0, 64'd0};
        tbl[2]  = '{32'h00FF_FFFF, 6'd2,  32'd1,          32'hFFFF_FFFF,  32'h003F_FFFF, 1'b1, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF};
        tbl[3]  = '{32'h00FF_FFFF, 6'd3,  32'h0001_0000,  32'h0001_0000,  32'h001F_FFFF, 1'b1, 1'b1, 1'b1, 64'h0000_0001_0000_0000};
        tbl[4]  = '{32'h00FF_FFFF, 6'd24, 32'h8000_0000,  32'd2,          32'h0000_0000, 1'b1, 1'b1, 1'b1, 64'h0000_0001_0000_0000};
        tbl[5]  = '{32'h00FF_FFFF, 6'd32, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFE_0000_0001};
        tbl[6]  = '{32'h0080_0001, 6'd4,  32'h00C0_0000,  32'h00C0_0000,  32'h0008_0000, 1'b0, 1'b0, 1'b1, 64'h0000_9000_0000_0000};
        tbl[7]  = '{32'hFFFF_FFFF, 6'd32, 32'd7,          32'd9,          32'h0000_0000, 1'b1, 1'b1, 1'b1, 64'd63};
        tbl[8]  = '{32'h8000_0000, 6'd31, 32'hFFFF_FFFF,  32'd1,          32'h0000_0001, 1'b0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF};
        tbl[9]  = '{32'hC000_0000, 6'd32, 32'd0,          32'd0,          32'h0000_0000, 1'b1, 1'b1, 1'b0, 64'd0};
        tbl[10] = '{32'h0000_0005, 6'd3,  32'h1234_5678,  32'd16,         32'h0000_0000, 1'b1, 1'b0, 1'b1, 64'h0000_0001_2345_6780};
        tbl[11] = '{32'hA5A5_A5A5, 6'd0,  32'h0001_0001,  32'h0001_0001,  32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 64'h0000_0001_0002_0001};

        // Reset with busy inputs: everything must read zero.
        fill_busy_inputs();
        reset = 1'b1;
        step();
        chk_all_zero("reset");

        // Alignment / GRS / product table, each vector on its own lane.
        reset = 1'b0;
        for (int i = 0; i < NV; i++) begin
            int lane;
            lane = i % NL;
            clear_inputs();
            i_valid = 1'b1;
            i_se[lane] = tbl[i].x;       i_shift[lane] = tbl[i].s;
            i_mcand[lane] = tbl[i].a;    i_mplier[lane] = tbl[i].b;
            step();
            chk($sformatf("v%0d se", i),     64'(o_se[lane]),     64'(tbl[i].e_se));
            chk($sformatf("v%0d guard", i),  64'(o_guard[lane]),  64'(tbl[i].e_g));
            chk($sformatf("v%0d round", i),  64'(o_round[lane]),  64'(tbl[i].e_r));
            chk($sformatf("v%0d sticky", i), 64'(o_sticky[lane]), 64'(tbl[i].e_st));
            chk($sformatf("v%0d prod", i),   o_prod[lane],        tbl[i].e_prod);
        end

        // Per-lane independence: lane k shifts FFFF_FFFF by k and multiplies (k+1)(k+2).
        clear_inputs();
        i_valid = 1'b1;
        for (int k = 0; k < NL; k++) begin
            i_se[k] = 32'hFFFF_FFFF; i_shift[k] = 6'(k);
            i_mcand[k] = 32'(k + 1); i_mplier[k] = 32'(k + 2);
        end
        step();
        for (int k = 0; k < NL; k++) begin
            logic [31:0] ones;
            ones = 32'hFFFF_FFFF;
            chk($sformatf("lane%0d se", k),   64'(o_se[k]),     64'(ones >> k));
            chk($sformatf("lane%0d grs", k),
                64'({o_guard[k], o_round[k], o_sticky[k]}),
                64'({k >= 1, k >= 2, k >= 3}));
            chk($sformatf("lane%0d prod", k), o_prod[k], 64'((k + 1) * (k + 2)));
        end

        // Back-to-back passthrough: before each edge the previous slot is still visible.
        for (int k = 0; k < 4; k++) begin
            drive_pt(k);
            #1;
            if (k > 0) begin
                chk($sformatf("pt%0d hold thread", k), 64'(o_thread), 64'(k - 1));
                chk($sformatf("pt%0d hold instr", k),  64'(o_instr),  64'(pt_instr(k - 1)));
            end
            step();
            chk_pt(k);
        end
        i_valid = 1'b0;
        step();
        chk("bubble valid", 64'(o_valid), 64'd0);

        // Reset mid-stream drops the slot; the next instruction emerges normally.
        fill_busy_inputs();
        reset = 1'b1;
        step();
        chk_all_zero("midreset");
        reset = 1'b0;
        clear_inputs();
        i_valid = 1'b1; i_instr = 32'h1234_5678; i_thread = 2'd2; i_mask = 16'h00A5;
        i_mcand[3] = 32'd1000; i_mplier[3] = 32'd1000;
        step();
        chk("post-reset valid",  64'(o_valid),  64'd1);
        chk("post-reset instr",  64'(o_instr),  64'h1234_5678);
        chk("post-reset thread", 64'(o_thread), 64'd2);
        chk("post-reset mask",   64'(o_mask),   64'h00A5);
        chk("post-reset prod",   o_prod[3],     64'd1_000_000);
        i_valid = 1'b0;
        step();
        chk("post-reset drain valid", 64'(o_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
